delta_encoder: RTL and testbench

Streaming delta encoder: converts a stream of signed samples into the load/add/init/a command stream consumed by `accumulator`. Feeding its output beats into an `accumulator` of the same `IN_WIDTH` reproduces every input sample exactly. Oversized steps are split into several saturated beats with catch-up. The block sits on the compression/replay side of the spike pipeline, upstream of the link that feeds the replay accumulator.

---
 rtl/dtree_pkg.sv | 22 ++
 rtl/delta_clamp.sv | 30 +++
 rtl/delta_encoder.sv | 162 ++++++++++++++++
 tb/tb_delta_encoder.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dtree_pkg.sv
// Shared definitions for the delta-tree compression blocks: delta encoder
// FSM state encoding and the signed delta range limits.
package dtree_pkg;

  typedef enum logic [1:0] {
    DE_IDLE    = 2'd0,
    DE_PRIME   = 2'd1,
    DE_TRACK   = 2'd2,
    DE_CATCHUP = 2'd3
  } de_state_e;

  // Largest delta representable in a w-bit two's-complement field.
  function automatic integer DELTA_MAX(input integer w);
    return (1 <<< (w - 1)) - 1;
  endfunction

  // Most negative delta representable in a w-bit two's-complement field.
  function automatic integer DELTA_MIN(input integer w);
    return -(1 <<< (w - 1));
  endfunction

endpackage

// File: rtl/delta_clamp.sv
// Saturates a wide signed difference into the IN_WIDTH-bit delta field and
// reports whether the difference fitted without saturation.
module delta_clamp
  import dtree_pkg::*;
#(
  parameter int IN_WIDTH = 14
) (
  input  logic signed [IN_WIDTH+1:0] diff_i,
  output logic signed [IN_WIDTH-1:0] delta_o,
  output logic                       fits_o
);

  localparam logic signed [IN_WIDTH+1:0] MAX_WIDE   = (IN_WIDTH+2)'(DELTA_MAX(IN_WIDTH));
  localparam logic signed [IN_WIDTH+1:0] MIN_WIDE   = (IN_WIDTH+2)'(DELTA_MIN(IN_WIDTH));
  localparam logic signed [IN_WIDTH-1:0] MAX_NARROW = IN_WIDTH'(DELTA_MAX(IN_WIDTH));
  localparam logic signed [IN_WIDTH-1:0] MIN_NARROW = IN_WIDTH'(DELTA_MIN(IN_WIDTH));

  // Range test and saturation; sign of the wide difference picks the rail.
  always_comb begin
    fits_o = (diff_i >= MIN_WIDE) && (diff_i <= MAX_WIDE);
    if (fits_o) begin
      delta_o = diff_i[IN_WIDTH-1:0];
    end else if (diff_i[IN_WIDTH+1]) begin
      delta_o = MIN_NARROW;
    end else begin
      delta_o = MAX_NARROW;
    end
  end

endmodule

// File: rtl/delta_encoder.sv
// Streaming delta encoder: turns signed samples into load/add command beats
// for a downstream accumulator. Steps too large for one delta are split into
// saturated beats (CATCHUP) until the accumulator mirror reaches the sample.
//
// Handshakes: both ports are strict valid/ready. A transfer happens on a
// rising clk edge where valid && ready. Once out_valid is high, the beat
// fields hold until out_ready takes it. in_ready never depends on in_valid.
module delta_encoder
  import dtree_pkg::*;
#(
  parameter int IN_WIDTH = 14
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic signed [IN_WIDTH:0]   sample,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       load,
  output logic                       add,
  output logic signed [IN_WIDTH:0]   init,
  output logic signed [IN_WIDTH-1:0] a,
  output logic                       lagging,
  output de_state_e                  dbg_state_o
);

  de_state_e state_q, state_d;

  // mirror: what the accumulator will hold after every emitted beat.
  logic signed [IN_WIDTH:0]   mirror_q, mirror_d;
  logic signed [IN_WIDTH:0]   target_q, target_d;

  logic                       out_valid_q, out_valid_d;
  logic                       load_q, load_d;
  logic                       add_q, add_d;
  logic signed [IN_WIDTH:0]   init_q, init_d;
  logic signed [IN_WIDTH-1:0] a_q, a_d;

  logic                       slot_free;
  logic                       accept;
  logic signed [IN_WIDTH:0]   diff_src;
  logic signed [IN_WIDTH+1:0] diff;
  logic signed [IN_WIDTH-1:0] delta;
  logic                       fits;
  logic signed [IN_WIDTH:0]   mirror_step;

  // Difference source: pending target in CATCHUP, incoming sample otherwise.
  always_comb begin
    diff_src    = (state_q == DE_CATCHUP) ? target_q : sample;
    diff        = {diff_src[IN_WIDTH], diff_src} - {mirror_q[IN_WIDTH], mirror_q};
    mirror_step = mirror_q + {delta[IN_WIDTH-1], delta};
  end

  delta_clamp #(
    .IN_WIDTH (IN_WIDTH)
  ) u_clamp (
    .diff_i  (diff),
    .delta_o (delta),
    .fits_o  (fits)
  );

  // Input handshake: start always blocks acceptance in its own cycle.
  always_comb begin
    slot_free = !out_valid_q || out_ready;
    in_ready  = !start && slot_free &&
                ((state_q == DE_PRIME) || (state_q == DE_TRACK));
    accept    = in_valid && in_ready;
  end

  // Next-state, mirror/target update and output-slot loading.
  always_comb begin
    state_d     = state_q;
    mirror_d    = mirror_q;
    target_d    = target_q;
    out_valid_d = out_valid_q;
    load_d      = load_q;
    add_d       = add_q;
    init_d      = init_q;
    a_d         = a_q;

    if (slot_free) begin
      out_valid_d = 1'b0;
      load_d      = 1'b0;
      add_d       = 1'b0;
      init_d      = '0;
      a_d         = '0;
    end

    if (start) begin
      // A pending beat survives; any residual is abandoned.
      state_d = DE_PRIME;
    end else begin
      case (state_q)
        DE_IDLE: ;
        DE_PRIME: begin
          if (accept) begin
            out_valid_d = 1'b1;
            load_d      = 1'b1;
            init_d      = sample;
            mirror_d    = sample;
            target_d    = sample;
            state_d     = DE_TRACK;
          end
        end
        DE_TRACK: begin
          if (accept) begin
            out_valid_d = 1'b1;
            add_d       = 1'b1;
            a_d         = delta;
            mirror_d    = mirror_step;
            target_d    = sample;
            if (!fits) state_d = DE_CATCHUP;
          end
        end
        DE_CATCHUP: begin
          if (slot_free) begin
            out_valid_d = 1'b1;
            add_d       = 1'b1;
            a_d         = delta;
            mirror_d    = mirror_step;
            if (fits) state_d = DE_TRACK;
          end
        end
        default: state_d = DE_IDLE;
      endcase
    end
  end

  // State and output-slot registers; reset drops any pending beat.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= DE_IDLE;
      mirror_q    <= '0;
      target_q    <= '0;
      out_valid_q <= 1'b0;
      load_q      <= 1'b0;
      add_q       <= 1'b0;
      init_q      <= '0;
      a_q         <= '0;
    end else begin
      state_q     <= state_d;
      mirror_q    <= mirror_d;
      target_q    <= target_d;
      out_valid_q <= out_valid_d;
      load_q      <= load_d;
      add_q       <= add_d;
      init_q      <= init_d;
      a_q         <= a_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign load        = load_q;
  assign add         = add_q;
  assign init        = init_q;
  assign a           = a_q;
  assign lagging     = (state_q == DE_CATCHUP);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_delta_encoder.sv
// Bench for delta_encoder: directed samples with hand-computed beats pushed
// to an expected queue; a monitor pops on each accepted beat and also keeps
// a reference accumulator to confirm sample reconstruction.
module tb_delta_encoder;
  import dtree_pkg::*;

  localparam int W = 14;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         in_valid;
  logic         in_ready;
  logic [W:0]   sample;
  logic         out_valid;
  logic         out_ready;
  logic         load;
  logic         add;
  logic [W:0]   init;
  logic [W-1:0] a;
  logic         lagging;
  de_state_e    dbg_state;

  typedef struct packed {
    logic         load;
    logic         add;
    logic [W:0]   init;
    logic [W-1:0] a;
    logic         chk;
    logic [W:0]   acc;
  } beat_t;

  beat_t      exp_q[$];
  int         n_checks = 0;
  int         n_errors = 0;
  logic [W:0] acc_m = '0;
  int         lag_cycles = 0;
  int         lag_ready_viol = 0;

  delta_encoder #(.IN_WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .sample      (sample),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .load        (load),
    .add         (add),
    .init        (init),
    .a           (a),
    .lagging     (lagging),
    .dbg_state_o (dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  function automatic beat_t mk(input bit ld, input bit ad, input int iv, input int av,
                               input bit chk, input int accv);
    beat_t b;
    b.load = ld;
    b.add  = ad;
    b.init = (W+1)'(iv);
    b.a    = W'(av);
    b.chk  = chk;
    b.acc  = (W+1)'(accv);
    return b;
  endfunction

  task automatic push_load(input int v);
    exp_q.push_back(mk(1'b1, 1'b0, v, 0, 1'b1, v));
  endtask

  task automatic push_add(input int d, input bit chk, input int accv);
    exp_q.push_back(mk(1'b0, 1'b1, 0, d, chk, accv));
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Offers one sample and returns 1 time unit after the accepting edge.
  task automatic send(input int v);
    bit ok;
    ok       = 1'b0;
    sample   = (W+1)'(v);
    in_valid = 1'b1;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
    end
    check("in_ready_wait", {31'b0, ok}, 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_out_valid"}, {31'b0, out_valid}, 32'd0);
    check({tag, "_load"},      {31'b0, load},      32'd0);
    check({tag, "_add"},       {31'b0, add},       32'd0);
    check({tag, "_init"},      32'(init),          32'd0);
    check({tag, "_a"},         32'(a),             32'd0);
    check({tag, "_lagging"},   {31'b0, lagging},   32'd0);
    check({tag, "_in_ready"},  {31'b0, in_ready},  32'd0);
    check({tag, "_state"},     32'(dbg_state),     32'(DE_IDLE));
  endtask

  // Scoreboard monitor and reference accumulator.
  always @(negedge clk) begin
    beat_t e;
    if (!reset) begin
      if (lagging) begin
        lag_cycles++;
        if (in_ready) lag_ready_viol++;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_beat: load=%0b add=%0b init=%0d a=%0d with empty queue", load, add, init, a);
        end else begin
          e = exp_q.pop_front();
          check("beat_load", {31'b0, load}, {31'b0, e.load});
          check("beat_add",  {31'b0, add},  {31'b0, e.add});
          check("beat_init", 32'(init),     32'(e.init));
          check("beat_a",    32'(a),        32'(e.a));
          if (load)     acc_m = init;
          else if (add) acc_m = acc_m + {a[W-1], a};
          if (e.chk) check("acc_y", 32'(acc_m), 32'(e.acc));
        end
      end
    end
  end

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    sample    = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk);
    #1 reset = 1'b0;

    // Small deltas, no lag.
    lag_cycles = 0;
    pulse_start();
    push_load(100);          send(100);
    push_add(3, 1'b1, 103);  send(103);
    push_add(-5, 1'b1, 98);  send(98);
    repeat (3) @(posedge clk);
    #1 check("t1_lag_cycles", 32'(lag_cycles), 32'd0);

    // Full-scale positive step, next sample waits out the catch-up.
    lag_cycles = 0;
    lag_ready_viol = 0;
    pulse_start();
    push_load(-16384);       send(-16384);
    push_add(8191, 1'b0, 0);
    push_add(8191, 1'b0, 0);
    push_add(8191, 1'b0, 0);
    push_add(8191, 1'b0, 0);
    push_add(3, 1'b1, 16383);
    send(16383);
    push_add(-3, 1'b1, 16380);
    send(16380);
    repeat (3) @(posedge clk);
    #1;
    check("t2_lag_cycles", 32'(lag_cycles), 32'd4);
    check("t2_ready_while_lag", 32'(lag_ready_viol), 32'd0);

    // Full-scale negative step.
    pulse_start();
    push_load(16383);        send(16383);
    push_add(-8192, 1'b0, 0);
    push_add(-8192, 1'b0, 0);
    push_add(-8192, 1'b0, 0);
    push_add(-8191, 1'b1, -16384);
    send(-16384);
    repeat (6) @(posedge clk);
    #1;

    // Output stall with input pending.
    pulse_start();
    push_load(50);           send(50);
    push_add(10, 1'b1, 60);  send(60);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    sample    = (W+1)'(70);
    repeat (5) begin
      @(negedge clk);
      check("stall_out_valid", {31'b0, out_valid}, 32'd1);
      check("stall_a",         32'(a),             32'd10);
      check("stall_in_ready",  {31'b0, in_ready},  32'd0);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    push_add(10, 1'b1, 70);  send(70);
    push_add(-5, 1'b1, 65);  send(65);

    // Start during CATCHUP with the first saturated beat still pending.
    pulse_start();
    push_load(0);            send(0);
    push_add(8191, 1'b1, 8191);
    send(16000);
    out_ready = 1'b0;
    start     = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    check("t5_lagging",   {31'b0, lagging},   32'd0);
    check("t5_out_valid", {31'b0, out_valid}, 32'd1);
    check("t5_pending_a", 32'(a),             32'd8191);
    check("t5_state",     32'(dbg_state),     32'(DE_PRIME));
    @(posedge clk);
    #1 out_ready = 1'b1;
    push_load(500);          send(500);

    // Reset mid-stream drops the pending beat and parks in IDLE.
    pulse_start();
    push_load(10);           send(10);
    send(20);
    out_ready = 1'b0;
    reset     = 1'b1;
    @(posedge clk);
    #1;
    reset     = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check_all_zero("midreset");
    in_valid = 1'b1;
    sample   = (W+1)'(33);
    repeat (3) begin
      @(negedge clk);
      check("idle_in_ready",  {31'b0, in_ready},  32'd0);
      check("idle_out_valid", {31'b0, out_valid}, 32'd0);
    end
    @(posedge clk);
    #1;
    push_load(7);
    pulse_start();
    send(7);

    // Drain: every expected beat must have been delivered.
    for (int t = 0; t < 50 && exp_q.size() != 0; t++) @(posedge clk);
    repeat (2) @(posedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
